// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared constants and types for the multi-precision add sequencer.
//   WORD_W     - width of one adder word
//   mp_state_e - sequencer states
//   word_t     - one datapath word
package mp_add_pkg;
    localparam int WORD_W = 16;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_e;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/project8.sv
// project8: 16-bit Kogge-Stone prefix adder, purely combinational.
//   a, b - addends
//   cin  - carry into bit 0
//   sum  - a + b + cin (low 16 bits)
//   cout - carry out of bit 15
module project8
    import mp_add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);
    logic [WORD_W-1:0] p, gg, pp, ng, np;
    logic [WORD_W:0]   c;
    // Four doubling levels; after level l each bit holds group G/P over 2^(l+1) bits.
    always_comb begin
        p  = a ^ b;
        gg = a & b;
        pp = p;
        ng = gg;
        np = pp;
        for (int l = 0; l < 4; l++) begin
            ng = gg;
            np = pp;
            for (int i = 1 << l; i < WORD_W; i++) begin
                ng[i] = gg[i] | (pp[i] & gg[i-(1<<l)]);
                np[i] = pp[i] & pp[i-(1<<l)];
            end
            gg = ng;
            pp = np;
        end
        c = {gg | (pp & {WORD_W{cin}}), cin};
    end
    assign sum  = p ^ c[WORD_W-1:0];
    assign cout = c[WORD_W];
endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer over one shared 16-bit adder.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operation request handshake (ready only in IDLE)
//   a, b, cin, sub      - operands, carry-in, subtract select (A-B, cin ignored)
//   out_valid/out_ready - result handshake, result held under backpressure
//   sum, cout           - 16*WORDS-bit result and carry out (sub: 1 = no borrow)
//   zero, ovf           - only with MPADD_FLAGS_EN: result-is-zero and signed overflow
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_W*WORDS-1:0] sum,
    output logic                  cout
`ifdef MPADD_FLAGS_EN
    ,
    output logic                  zero,
    output logic                  ovf
`endif
);
    localparam int CW = $clog2(WORDS);
    localparam int W  = WORD_W * WORDS;

    mp_state_e   state, state_nx;
    logic [W-1:0] op_a, op_b, sum_nx;
    logic [CW-1:0] idx;
    logic        carry, c_w, last;
    word_t       a_w, b_w, s_w;

    assign a_w  = op_a[int'(idx)*WORD_W +: WORD_W];
    assign b_w  = op_b[int'(idx)*WORD_W +: WORD_W];
    assign last = idx == CW'(WORDS - 1);

    project8 u_add (
        .a    (a_w),
        .b    (b_w),
        .cin  (carry),
        .sum  (s_w),
        .cout (c_w)
    );

    // Current result with the word being produced this cycle merged in.
    always_comb begin
        sum_nx = sum;
        sum_nx[int'(idx)*WORD_W +: WORD_W] = s_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
    end

    // Operands need no reset: they are always loaded before RUN reads them.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            op_a <= a;
            op_b <= sub ? ~b : b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef MPADD_FLAGS_EN
            zero  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            idx   <= '0;
            carry <= sub ? 1'b1 : cin;
        end else if (state == RUN) begin
            sum   <= sum_nx;
            carry <= c_w;
            idx   <= idx + 1'b1;
            if (last) begin
                cout <= c_w;
`ifdef MPADD_FLAGS_EN
                zero <= sum_nx == '0;
                ovf  <= (op_a[W-1] == op_b[W-1]) && (s_w[WORD_W-1] != op_a[W-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: directed and randomized checks of mp_add_seq against a behavioural model.
module tb_mp_add_seq;
    localparam int WORDS = 4;
    localparam int W = 16 * WORDS;
    typedef logic [W:0] v_t;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, cout;
    logic [W-1:0] a = '0, b = '0, sum;
`ifdef MPADD_FLAGS_EN
    logic zero, ovf;
`endif

    int vectors = 0, miscompares = 0;
    int cyc = 0, acc = 0;
    bit pend = 1'b0, chk_en = 1'b0, ev = 1'b0;
    v_t exp_res = '0;
    logic exp_ovf = 1'b0;

    mp_add_seq #(.WORDS(WORDS)) dut (
`ifdef MPADD_FLAGS_EN
        .zero      (zero),
        .ovf       (ovf),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, v_t act, v_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic v_t ref_add(logic [W-1:0] x, logic [W-1:0] y, logic c, logic s);
        logic [W-1:0] yy;
        yy = s ? ~y : y;
        return {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s | c};
    endfunction

    function automatic logic ref_ovf(logic [W-1:0] x, logic [W-1:0] y, logic c, logic s);
        logic [W-1:0] yy;
        v_t r;
        yy = s ? ~y : y;
        r = ref_add(x, y, c, s);
        return (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Transaction-level model: one pending op, result visible WORDS edges after accept.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pend <= 1'b0;
        end else if (!pend) begin
            if (in_valid) begin
                pend    <= 1'b1;
                acc     <= cyc + 1;
                exp_res <= ref_add(a, b, cin, sub);
                exp_ovf <= ref_ovf(a, b, cin, sub);
            end
        end else if (cyc >= acc + WORDS && out_ready) begin
            pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            ev = pend && cyc >= acc + WORDS;
            chk("in_ready", v_t'(in_ready), v_t'(!pend));
            chk("out_valid", v_t'(out_valid), v_t'(ev));
            if (ev) begin
                chk("sum", v_t'(sum), v_t'(exp_res[W-1:0]));
                chk("cout", v_t'(cout), v_t'(exp_res[W]));
`ifdef MPADD_FLAGS_EN
                chk("zero", v_t'(zero), v_t'(exp_res[W-1:0] == '0));
                chk("ovf", v_t'(ovf), v_t'(exp_ovf));
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts,
                          input int hold, input logic [W-1:0] es, input logic ec, input logic ez,
                          input logic eo, input bit keep);
        int n;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", v_t'(in_ready), v_t'(1));
        @(posedge clk); #1;
        in_valid = keep;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom); sub = 1'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", v_t'(n), v_t'(WORDS));
        chk("model_pin", exp_res, {ec, es});
        repeat (hold) begin
            chk("hold_sum", {cout, sum}, {ec, es});
            chk("hold_in_ready", v_t'(in_ready), v_t'(0));
            chk("hold_out_valid", v_t'(out_valid), v_t'(1));
            @(posedge clk); #1;
        end
        chk("sum_lit", {cout, sum}, {ec, es});
`ifdef MPADD_FLAGS_EN
        chk("zero_lit", v_t'(zero), v_t'(ez));
        chk("ovf_lit", v_t'(ovf), v_t'(eo));
`else
        if (ez === 1'bx || eo === 1'bx) chk("flag_arg", v_t'(0), v_t'(1));
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drop", v_t'(out_valid), v_t'(0));
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_sum", {cout, sum}, '0);
        chk("rst_in_ready", v_t'(in_ready), v_t'(1));
        chk("rst_out_valid", v_t'(out_valid), v_t'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(64'h5, 64'h7, 1'b0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(64'h7, 64'h5, 1'b1, 1'b1, 0, 64'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 3, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);

        a = 64'hDEAD_BEEF_0000_1111; b = 64'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_in_ready", v_t'(in_ready), v_t'(1));
        chk("rst_mid_out_valid", v_t'(out_valid), v_t'(0));
        repeat (8) begin
            @(posedge clk); #1;
            chk("rst_no_valid", v_t'(out_valid), v_t'(0));
        end
        run_op(64'h1234, 64'h5678, 1'b0, 1'b0, 0, 64'h68AC, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op(64'h1, 64'h2, 1'b0, 1'b0, 1, 64'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(64'h10, 64'h1, 1'b0, 1'b1, 0, 64'hF, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            rst       = ($urandom % 150) == 0;
            case ($urandom % 4)
                0: a = '1;
                1: a = {$urandom, $urandom};
                2: a = {1'b0, {(W-1){1'b1}}};
                default: a = {$urandom, $urandom};
            endcase
            b   = ($urandom % 5 == 0) ? '0 : {$urandom, $urandom};
            cin = 1'($urandom);
            sub = 1'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (WORDS + 4) begin
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
